rand_range_core: RTL and testbench

Uniform bounded random-number engine that sits directly upstream of the `tt_um_` top-level wrapper's `uo_out` pins. A Galois LFSR free-runs while the design is enabled. On a request, the block draws samples by masked rejection sampling until one falls in `[0, limit]`. It returns the sample over a valid/ack handshake, and falls back to a deterministic fold after a bounded number of tries.

---
 rtl/rand_pkg.sv | 29 ++
 rtl/lfsr_galois.sv | 45 ++++
 rtl/rand_range_core.sv | 151 +++++++++++++++
 tb/tb_rand_range_core.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rand_pkg.sv
// Shared types and constants for the bounded random-number engine.
package rand_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] DEFAULT_TAPS = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Width of the mask helper; result widths up to this size are supported.
    localparam int MASK_W = 32;

    // Smallest all-ones value that is >= limit (zero for a zero limit).
    // Smearing the highest set bit downwards gives exactly that value.
    function automatic logic [MASK_W-1:0] mask_of(input logic [MASK_W-1:0] limit);
        logic [MASK_W-1:0] m;
        m = limit;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        m = m | (m >> 8);
        m = m | (m >> 16);
        return m;
    endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Galois LFSR with synchronous reseed. A zero reseed value is replaced by
// SEED, and a nonzero Galois state can never step to zero, so the register
// cannot lock up.
module lfsr_galois
    import rand_pkg::*;
#(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEFAULT_TAPS),
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEFAULT_SEED)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] stepped;
    logic [LFSR_W-1:0] reseed;

    // One Galois step: shift right and fold the feedback mask in when the lsb was set.
    always_comb begin
        stepped = state >> 1;
        if (state[0]) begin
            stepped = stepped ^ TAPS;
        end
    end

    assign reseed = (load_val == '0) ? SEED : load_val;

    // State register: reseed takes priority over stepping; nothing moves while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (en) begin
            if (load) begin
                state <= reseed;
            end else begin
                state <= stepped;
            end
        end
    end

endmodule

// File: rtl/rand_range_core.sv
// Uniform bounded random-number engine. Draws masked LFSR samples until one
// lands in [0, limit], folding the last candidate back into range if the try
// budget runs out, and hands the result over a valid/ack handshake.
module rand_range_core
    import rand_pkg::*;
#(
    parameter int                WIDTH     = 8,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] TAPS      = LFSR_W'(DEFAULT_TAPS),
    parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(DEFAULT_SEED),
    parameter int                MAX_TRIES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic              req,
    input  logic [WIDTH-1:0]  limit,
    input  logic              ack,
    output logic              busy,
    output logic              valid,
    output logic [WIDTH-1:0]  value,
    output logic              fallback
);

    // Try counter only needs to reach MAX_TRIES-1.
    localparam int                TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0]  LAST_TRY = TRY_W'(MAX_TRIES - 1);

    // Fold an out-of-range candidate back into [0, lim]. The candidate is
    // masked to at most 2*lim+1, so the difference never underflows.
    function automatic logic [WIDTH-1:0] fold(input logic [WIDTH-1:0] cand_v,
                                              input logic [WIDTH-1:0] lim);
        return cand_v - lim - WIDTH'(1);
    endfunction

    state_t             state_q, state_d;
    logic [TRY_W-1:0]   tries_q, tries_d;
    logic [WIDTH-1:0]   limit_q, limit_d;
    logic [WIDTH-1:0]   mask_q, mask_d;
    logic [WIDTH-1:0]   value_d;
    logic               fallback_d;
    logic               busy_d;
    logic               valid_d;
    logic               seed_hit;

    logic [LFSR_W-1:0]  lfsr_state;
    logic [WIDTH-1:0]   cand;
    logic [MASK_W-1:0]  mask_wide;

    lfsr_galois #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS),
        .SEED   (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (ena),
        .load     (seed_hit),
        .load_val (seed_in),
        .state    (lfsr_state)
    );

    assign mask_wide = mask_of(MASK_W'(limit));
    assign cand      = lfsr_state[WIDTH-1:0] & mask_q;

    // Bits above the result width are not part of any draw.
    if (WIDTH < MASK_W) begin : g_mask_hi
        logic unused_mask_hi;
        assign unused_mask_hi = ^mask_wide[MASK_W-1:WIDTH];
    end
    if (LFSR_W > WIDTH) begin : g_lfsr_hi
        logic unused_lfsr_hi;
        assign unused_lfsr_hi = ^lfsr_state[LFSR_W-1:WIDTH];
    end

    // Next-state and next-output logic; everything holds unless ena is high.
    always_comb begin
        state_d    = state_q;
        tries_d    = tries_q;
        limit_d    = limit_q;
        mask_d     = mask_q;
        value_d    = value;
        fallback_d = fallback;
        seed_hit   = 1'b0;

        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (seed_load) begin
                        seed_hit = 1'b1;
                    end else if (req) begin
                        limit_d = limit;
                        mask_d  = mask_wide[WIDTH-1:0];
                        tries_d = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (cand <= limit_q) begin
                        value_d    = cand;
                        fallback_d = 1'b0;
                        state_d    = DONE;
                    end else if (tries_q == LAST_TRY) begin
                        value_d    = fold(cand, limit_q);
                        fallback_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        tries_d = tries_q + 1'b1;
                    end
                end
                DONE: begin
                    if (ack) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d  = (state_d != IDLE);
        valid_d = (state_d == DONE);
    end

    // Control and result registers; outputs come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            tries_q  <= '0;
            limit_q  <= '0;
            mask_q   <= '0;
            value    <= '0;
            fallback <= 1'b0;
            busy     <= 1'b0;
            valid    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tries_q  <= tries_d;
            limit_q  <= limit_d;
            mask_q   <= mask_d;
            value    <= value_d;
            fallback <= fallback_d;
            busy     <= busy_d;
            valid    <= valid_d;
        end
    end

endmodule

// File: tb/tb_rand_range_core.sv
// Bench for rand_range_core: two instances (default try budget and a budget
// of two) share one stimulus stream and are checked every cycle against a
// transaction-level model, plus hand-worked literal results.
module tb_rand_range_core;

    localparam int NDUT = 2;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        seed_load;
    logic [15:0] seed_in;
    logic        req;
    logic [7:0]  limit;
    logic        ack;

    logic [1:0]  busy_w;
    logic [1:0]  valid_w;
    logic [1:0]  fb_w;
    logic [7:0]  value0;
    logic [7:0]  value1;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state per instance
    logic [15:0] m_lfsr  [NDUT];
    bit          m_busy  [NDUT];
    bit          m_valid [NDUT];
    logic [7:0]  m_value [NDUT];
    bit          m_fb    [NDUT];
    logic [7:0]  m_pv    [NDUT];
    bit          m_pfb   [NDUT];
    int          m_left  [NDUT];

    rand_range_core #(
        .WIDTH(8), .LFSR_W(16), .TAPS(16'hB400), .SEED(16'hACE1), .MAX_TRIES(16)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .seed_load(seed_load), .seed_in(seed_in),
        .req(req), .limit(limit), .ack(ack), .busy(busy_w[0]), .valid(valid_w[0]),
        .value(value0), .fallback(fb_w[0])
    );

    rand_range_core #(
        .WIDTH(8), .LFSR_W(16), .TAPS(16'hB400), .SEED(16'hACE1), .MAX_TRIES(2)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .seed_load(seed_load), .seed_in(seed_in),
        .req(req), .limit(limit), .ack(ack), .busy(busy_w[1]), .valid(valid_w[1]),
        .value(value1), .fallback(fb_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int mt_of(input int k);
        return (k == 0) ? 16 : 2;
    endfunction

    function automatic logic [7:0] value_of(input int k);
        return (k == 0) ? value0 : value1;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic int smallest_mask(input int lim);
        int m;
        m = 0;
        while (m < lim) m = m * 2 + 1;
        return m;
    endfunction

    // Whole draw for a request accepted with LFSR state s0: result, fold flag
    // and how many enabled RUN cycles it takes.
    task automatic draw(input logic [15:0] s0, input int lim, input int mt,
                        output int val, output bit fb, output int len);
        logic [15:0] s;
        int mask;
        int cand;
        s    = lfsr_next(s0);
        mask = smallest_mask(lim);
        val  = 0;
        fb   = 1'b0;
        len  = mt;
        for (int i = 0; i < mt; i++) begin
            cand = int'(s[7:0]) & mask;
            if (cand <= lim) begin
                val = cand; fb = 1'b0; len = i + 1;
                return;
            end
            if (i == mt - 1) begin
                val = cand - lim - 1; fb = 1'b1; len = mt;
                return;
            end
            s = lfsr_next(s);
        end
    endtask

    task automatic model_reset(input int k);
        m_lfsr[k]  = 16'hACE1;
        m_busy[k]  = 1'b0;
        m_valid[k] = 1'b0;
        m_value[k] = 8'h00;
        m_fb[k]    = 1'b0;
        m_pv[k]    = 8'h00;
        m_pfb[k]   = 1'b0;
        m_left[k]  = 0;
    endtask

    task automatic model_step(input int k);
        int v; bit f; int n;
        if (!rst_n) begin
            model_reset(k);
        end else if (ena) begin
            if (!m_busy[k]) begin
                if (seed_load) begin
                    m_lfsr[k] = (seed_in == 16'h0) ? 16'hACE1 : seed_in;
                end else begin
                    if (req) begin
                        draw(m_lfsr[k], int'(limit), mt_of(k), v, f, n);
                        m_pv[k]   = 8'(v);
                        m_pfb[k]  = f;
                        m_left[k] = n;
                        m_busy[k] = 1'b1;
                    end
                    m_lfsr[k] = lfsr_next(m_lfsr[k]);
                end
            end else if (!m_valid[k]) begin
                m_lfsr[k] = lfsr_next(m_lfsr[k]);
                m_left[k] = m_left[k] - 1;
                if (m_left[k] == 0) begin
                    m_valid[k] = 1'b1;
                    m_value[k] = m_pv[k];
                    m_fb[k]    = m_pfb[k];
                end
            end else begin
                m_lfsr[k] = lfsr_next(m_lfsr[k]);
                if (ack) begin
                    m_busy[k]  = 1'b0;
                    m_valid[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic check(input string what, input int k,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h", what, k, act, exp);
        end
    endtask

    initial begin : model
        for (int k = 0; k < NDUT; k++) model_reset(k);
        forever begin
            @(posedge clk or negedge rst_n);
            for (int k = 0; k < NDUT; k++) model_step(k);
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            for (int k = 0; k < NDUT; k++) begin
                check("busy", k, 32'(busy_w[k]), 32'(m_busy[k]));
                check("valid", k, 32'(valid_w[k]), 32'(m_valid[k]));
                check("value", k, 32'(value_of(k)), 32'(m_value[k]));
                check("fallback", k, 32'(fb_w[k]), 32'(m_fb[k]));
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Async reset pulse inside the low clock phase; outputs must clear at once.
    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check("arst_valid", k, 32'(valid_w[k]), 32'd0);
            check("arst_busy", k, 32'(busy_w[k]), 32'd0);
            check("arst_value", k, 32'(value_of(k)), 32'd0);
        end
        #1 rst_n = 1'b1;
    endtask

    // Reseed, request, wait for both results, then ack (or reset) and check
    // latencies and results against hand-worked values.
    task automatic run_txn(input logic [15:0] seed, input logic [7:0] lim,
                           input int gap, input bit poke, input bit end_rst,
                           input int e_lat0, input int e_lat1,
                           input logic [7:0] e_v0, input logic [7:0] e_v1,
                           input bit e_f0, input bit e_f1);
        int lat0, lat1;
        ena = 1'b1; ack = 1'b0; req = 1'b0;
        seed_load = 1'b1; seed_in = seed;
        @(negedge clk);
        check("seed_loaded", 0, 32'(u_dut0.u_lfsr.state),
              (seed == 16'h0) ? 32'hACE1 : 32'(seed));
        seed_load = 1'b0; req = 1'b1; limit = lim;
        @(negedge clk);
        req = 1'b0;
        lat0 = -1; lat1 = -1;
        for (int c = 1; c <= 40; c++) begin
            ena = !((c >= 2) && (c < 2 + gap));
            req = poke; seed_load = poke;
            if (poke) begin
                limit = 8'h01; seed_in = 16'h1234;
            end
            @(negedge clk);
            if (lat0 < 0 && valid_w[0]) lat0 = c;
            if (lat1 < 0 && valid_w[1]) lat1 = c;
            if (lat0 >= 0 && lat1 >= 0) break;
        end
        ena = 1'b1; req = 1'b0; seed_load = 1'b0;
        check("latency", 0, 32'(lat0), 32'(e_lat0));
        check("latency", 1, 32'(lat1), 32'(e_lat1));
        check("lit_value", 0, 32'(value0), 32'(e_v0));
        check("lit_value", 1, 32'(value1), 32'(e_v1));
        check("lit_fallback", 0, 32'(fb_w[0]), 32'(e_f0));
        check("lit_fallback", 1, 32'(fb_w[1]), 32'(e_f1));
        check("model_value", 0, 32'(m_value[0]), 32'(e_v0));
        check("model_value", 1, 32'(m_value[1]), 32'(e_v1));
        if (end_rst) begin
            reset_pulse();
            @(negedge clk);
        end else begin
            ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
            check("ack_clears", 0, 32'(valid_w[0]), 32'd0);
            check("ack_clears", 1, 32'(valid_w[1]), 32'd0);
        end
    endtask

    initial begin : stim
        rst_n = 1'b0; ena = 1'b0; seed_load = 1'b0; seed_in = 16'h0;
        req = 1'b0; limit = 8'h00; ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_lfsr", 0, 32'(u_dut0.u_lfsr.state), 32'hACE1);
        for (int k = 0; k < NDUT; k++) begin
            check("rst_busy", k, 32'(busy_w[k]), 32'd0);
            check("rst_valid", k, 32'(valid_w[k]), 32'd0);
            check("rst_value", k, 32'(value_of(k)), 32'd0);
            check("rst_fallback", k, 32'(fb_w[k]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Full range: first candidate 0x70 accepted.
        run_txn(16'hACE1, 8'hFF, 0, 1'b0, 1'b0, 1, 1, 8'h70, 8'h70, 1'b0, 1'b0);
        // limit 0x20: 0x30, 0x38 rejected, 0x1C accepted; budget 2 folds 0x38 to 0x17.
        // req/seed_load/limit wiggling while busy must be ignored.
        run_txn(16'hACE1, 8'h20, 0, 1'b1, 1'b0, 3, 2, 8'h1C, 8'h17, 1'b0, 1'b1);
        // Zero seed substitutes the default seed; limit 0 always yields 0.
        run_txn(16'h0000, 8'h00, 0, 1'b0, 1'b0, 1, 1, 8'h00, 8'h00, 1'b0, 1'b0);
        // Five frozen cycles mid-RUN delay the result by exactly five cycles.
        run_txn(16'hACE1, 8'h20, 5, 1'b0, 1'b0, 8, 7, 8'h1C, 8'h17, 1'b0, 1'b1);
        // Reset pulse while results are pending.
        run_txn(16'hACE1, 8'hFF, 0, 1'b0, 1'b1, 1, 1, 8'h70, 8'h70, 1'b0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            ena       = ($urandom_range(0, 9) != 0);
            req       = ($urandom_range(0, 2) == 0);
            ack       = ($urandom_range(0, 2) == 0);
            seed_load = ($urandom_range(0, 19) == 0);
            seed_in   = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            case ($urandom_range(0, 3))
                0:       limit = 8'h00;
                1:       limit = 8'hFF;
                2:       limit = 8'($urandom_range(0, 15));
                default: limit = 8'($urandom);
            endcase
            if ($urandom_range(0, 299) == 0) reset_pulse();
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
